// File: rtl/mem_model_sync.sv
// mem_model_sync: single-port synchronous word memory with a registered
// read port and a one-cycle acknowledge pulse for every accepted access.
//
// Request/acknowledge semantics: a request is presented by raising exactly
// one of wr/rd for one cycle with an in-range addr. It is accepted at the
// sampling edge and acknowledged by response=1 during the following cycle.
// rdata is also valid in that cycle. There is no back-pressure, so every
// legal request is accepted. Illegal requests (wr and rd together, or an
// out-of-range address) are dropped silently, and response stays 0.
module mem_model_sync #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_SIZE   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  rd,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  response
);

    // Widened by one bit so the bound still compares correctly when
    // MEM_SIZE equals 2**ADDR_WIDTH.
    localparam logic [ADDR_WIDTH:0] MEM_SIZE_EXT = (ADDR_WIDTH + 1)'(MEM_SIZE);

    logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

    logic in_range;
    logic do_write;
    logic do_read;
    logic accept;

    // Decode the request: only a single, in-range operation is accepted.
    always_comb begin
        in_range = ({1'b0, addr} < MEM_SIZE_EXT);
        do_write = wr && !rd && in_range;
        do_read  = rd && !wr && in_range;
        accept   = do_write || do_read;
    end

    // Storage, read register and acknowledge. Reset clears everything and
    // overrides any request sampled in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem      <= '{default: '0};
            rdata    <= '0;
            response <= 1'b0;
        end else begin
            response <= accept;
            if (do_write) begin
                mem[addr] <= wdata;
            end
            if (do_read) begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: tb/tb_mem_model_sync.sv
// tb_mem_model_sync: directed plus randomized checks of mem_model_sync
// against an array-based reference model of the memory.
module tb_mem_model_sync;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int N  = 16;

    logic          clk;
    logic          reset;
    logic          wr;
    logic          rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          response;

    int total;
    int bad;

    // Reference state: plain word array, last read value, last acknowledge.
    logic [DW-1:0] ref_mem [N];
    logic [DW-1:0] ref_rdata;
    logic          ref_resp;
    logic [DW-1:0] exp_q [$];

    mem_model_sync #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .MEM_SIZE  (N)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .wr      (wr),
        .rd      (rd),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .response(response)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic check_val(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("FAIL %s: got=%h want=%h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drive one cycle, advance the model by the memory's rules, then check
    // the outputs shortly after the sampling edge.
    task automatic do_cycle(input logic c_rst, input logic c_wr, input logic c_rd,
                            input logic [AW-1:0] c_addr, input logic [DW-1:0] c_wdata);
        logic          was_read;
        logic [DW-1:0] exp_data;
        reset = c_rst;
        wr    = c_wr;
        rd    = c_rd;
        addr  = c_addr;
        wdata = c_wdata;
        was_read = 1'b0;
        @(posedge clk);
        if (c_rst) begin
            for (int i = 0; i < N; i++) ref_mem[i] = '0;
            ref_rdata = '0;
            ref_resp  = 1'b0;
        end else if (c_wr && c_rd) begin
            ref_resp = 1'b0;
        end else if (c_wr) begin
            ref_mem[int'(c_addr)] = c_wdata;
            ref_resp = 1'b1;
        end else if (c_rd) begin
            ref_rdata = ref_mem[int'(c_addr)];
            ref_resp  = 1'b1;
            exp_q.push_back(ref_mem[int'(c_addr)]);
            was_read = 1'b1;
        end else begin
            ref_resp = 1'b0;
        end
        #1;
        check_val("response", {31'b0, response}, {31'b0, ref_resp});
        check_val("rdata", rdata, ref_rdata);
        if (was_read) begin
            exp_data = exp_q.pop_front();
            check_val("read_data", rdata, exp_data);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        wr    = 1'b0;
        rd    = 1'b0;
        addr  = '0;
        wdata = '0;
        for (int i = 0; i < N; i++) ref_mem[i] = 'x;
        ref_rdata = 'x;
        ref_resp  = 1'b0;

        // Reset clear: two reset cycles, then every location reads 0.
        do_cycle(1'b1, 1'b0, 1'b0, '0, '0);
        do_cycle(1'b1, 1'b0, 1'b0, '0, '0);
        check_val("reset_rdata", rdata, 32'h0);
        for (int a = 0; a < N; a++) do_cycle(1'b0, 1'b0, 1'b1, AW'(a), '0);

        // Write all locations (rdata must hold), then read them back.
        for (int a = 0; a < N; a++) do_cycle(1'b0, 1'b1, 1'b0, AW'(a), 32'hA5A50000 + a);
        for (int a = 0; a < N; a++) do_cycle(1'b0, 1'b0, 1'b1, AW'(a), '0);
        check_val("last_readback", rdata, 32'hA5A5000F);

        // Read-after-write on the same address.
        do_cycle(1'b0, 1'b1, 1'b0, 4'd7, 32'hDEADBEEF);
        do_cycle(1'b0, 1'b0, 1'b1, 4'd7, '0);
        check_val("raw_addr7", rdata, 32'hDEADBEEF);

        // Illegal request leaves memory, rdata and response untouched.
        do_cycle(1'b0, 1'b1, 1'b0, 4'd3, 32'h11111111);
        do_cycle(1'b0, 1'b1, 1'b1, 4'd3, 32'h12345678);
        check_val("illegal_resp", {31'b0, response}, 32'h0);
        check_val("illegal_rdata", rdata, 32'hDEADBEEF);
        do_cycle(1'b0, 1'b0, 1'b1, 4'd3, '0);
        check_val("illegal_mem", rdata, 32'h11111111);

        // Mid-stream reset discards earlier contents.
        do_cycle(1'b0, 1'b1, 1'b0, 4'd15, 32'hFFFFFFFF);
        do_cycle(1'b1, 1'b0, 1'b0, 4'd15, '0);
        check_val("midrst_rdata", rdata, 32'h0);
        check_val("midrst_resp", {31'b0, response}, 32'h0);
        do_cycle(1'b0, 1'b0, 1'b1, 4'd15, '0);
        check_val("midrst_read", rdata, 32'h0);

        // Back-to-back alternating write/read on addresses 0 and 1.
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) do_cycle(1'b0, 1'b1, 1'b0, AW'(k / 2 % 2), 32'hC0DE0000 + k);
            else            do_cycle(1'b0, 1'b0, 1'b1, AW'((k - 1) / 2 % 2), '0);
            check_val("b2b_resp", {31'b0, response}, 32'h1);
        end

        // Randomized traffic, including idle, illegal and rare reset cycles.
        for (int k = 0; k < 400; k++) begin
            int sel;
            sel = $urandom_range(0, 99);
            if (sel < 2)       do_cycle(1'b1, 1'($urandom), 1'($urandom), AW'($urandom), $urandom);
            else if (sel < 40) do_cycle(1'b0, 1'b1, 1'b0, AW'($urandom), $urandom);
            else if (sel < 80) do_cycle(1'b0, 1'b0, 1'b1, AW'($urandom), $urandom);
            else if (sel < 88) do_cycle(1'b0, 1'b1, 1'b1, AW'($urandom), $urandom);
            else               do_cycle(1'b0, 1'b0, 1'b0, AW'($urandom), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
